// File: rtl/madd_sequencer.sv
// Program sequencer for the DMADD datapath: buffers host words, replays them as timed load/run strobes.
// Host writes stall (cmd_ready low) outside IDLE, when the buffer is full, or while clear/start is asserted.
module madd_sequencer #(
  parameter int DEPTH    = 16,
  parameter int EXEC_LAT = 2,
  parameter int RES_W    = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [11:0]      cmd_word,
  input  logic             clear,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             madd_load,
  output logic             madd_run,
  output logic [1:0]       madd_insn,
  output logic [3:0]       madd_index,
  output logic [3:0]       madd_data,
  input  logic [RES_W-1:0] madd_result,
  output logic             res_valid,
  output logic [RES_W-1:0] res_data
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;
  localparam int LAT_W = $clog2(EXEC_LAT) + 1;
  localparam logic [PTR_W-1:0] DEPTH_P  = PTR_W'(DEPTH);
  localparam logic [LAT_W-1:0] EXW_INIT = LAT_W'((EXEC_LAT > 1) ? EXEC_LAT - 2 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_EXWAIT, S_CAPTURE, S_DELAY, S_DONE
  } state_e;

  typedef enum logic [1:0] {
    K_LOAD  = 2'b00,
    K_EXEC  = 2'b01,
    K_DELAY = 2'b10,
    K_HALT  = 2'b11
  } kind_e;

  state_e           state_q, state_d;
  logic [11:0]      mem_q [DEPTH];
  logic [11:0]      mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] pc_q, pc_d;
  logic [11:0]      ir_q, ir_d;
  logic [3:0]       dly_q, dly_d;
  logic [LAT_W-1:0] exw_q, exw_d;
  logic             res_valid_q, res_valid_d;
  logic [RES_W-1:0] res_data_q, res_data_d;
  logic             wr_en;
  kind_e            ir_kind;

  // wr_ptr doubles as the entry count; its extra MSB separates full from empty.
  assign cmd_ready = (state_q == S_IDLE) && (wr_ptr_q < DEPTH_P) && !clear && !start;
  assign wr_en     = cmd_valid && cmd_ready;
  assign ir_kind   = kind_e'(ir_q[11:10]);
  assign busy      = (state_q != S_IDLE);
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;

  always_comb begin
    state_d     = state_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    dly_d       = dly_q;
    exw_d       = exw_q;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    done        = 1'b0;
    madd_load   = 1'b0;
    madd_run    = 1'b0;
    madd_insn   = 2'd0;
    madd_index  = 4'd0;
    madd_data   = 4'd0;

    if (wr_en) begin
      mem_d[wr_ptr_q[AW-1:0]] = cmd_word;
      wr_ptr_d                = wr_ptr_q + PTR_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d    = '0;
          state_d = (wr_ptr_q != '0) ? S_FETCH : S_DONE;
        end else if (clear) begin
          wr_ptr_d = '0;
        end
      end
      S_FETCH: begin
        if (pc_q == wr_ptr_q) begin
          state_d = S_DONE;
        end else begin
          ir_d    = mem_q[pc_q[AW-1:0]];
          pc_d    = pc_q + PTR_W'(1);
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        madd_insn  = ir_q[9:8];
        madd_index = ir_q[7:4];
        madd_data  = ir_q[3:0];
        case (ir_kind)
          K_LOAD: begin
            madd_load = 1'b1;
            state_d   = S_FETCH;
          end
          K_EXEC: begin
            madd_run = 1'b1;
            exw_d    = EXW_INIT;
            state_d  = (EXEC_LAT > 1) ? S_EXWAIT : S_CAPTURE;
          end
          K_DELAY: begin
            dly_d   = ir_q[3:0];
            state_d = S_DELAY;
          end
          default: state_d = S_DONE;
        endcase
      end
      S_EXWAIT: begin
        // Operands stay on the bus while the datapath computes.
        madd_insn  = ir_q[9:8];
        madd_index = ir_q[7:4];
        madd_data  = ir_q[3:0];
        if (exw_q == '0) state_d = S_CAPTURE;
        else             exw_d   = exw_q - LAT_W'(1);
      end
      S_CAPTURE: begin
        res_data_d  = madd_result;
        res_valid_d = 1'b1;
        state_d     = S_FETCH;
      end
      S_DELAY: begin
        if (dly_q == 4'd0) state_d = S_FETCH;
        else               dly_d   = dly_q - 4'd1;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything in flight, including a pending capture.
    if (abort && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      done        = 1'b0;
      madd_load   = 1'b0;
      madd_run    = 1'b0;
      madd_insn   = 2'd0;
      madd_index  = 4'd0;
      madd_data   = 4'd0;
      res_valid_d = 1'b0;
      res_data_d  = res_data_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      pc_q        <= '0;
      ir_q        <= '0;
      dly_q       <= '0;
      exw_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      dly_q       <= dly_d;
      exw_q       <= exw_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

endmodule

// File: tb/tb_madd_sequencer.sv
// Bench for madd_sequencer: handshake table, directed program sequences and random programs
// checked cycle by cycle against a timeline derived from the word-kind rules.
module tb_madd_sequencer;

  localparam int DEPTH    = 16;
  localparam int EXEC_LAT = 2;
  localparam int RES_W    = 12;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [11:0]      cmd_word = '0;
  logic             clear = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             busy, done, madd_load, madd_run;
  logic [1:0]       madd_insn;
  logic [3:0]       madd_index, madd_data;
  logic [RES_W-1:0] madd_result;
  logic             res_valid;
  logic [RES_W-1:0] res_data;

  always #5 clk = ~clk;

  madd_sequencer #(.DEPTH(DEPTH), .EXEC_LAT(EXEC_LAT), .RES_W(RES_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_word(cmd_word),
    .clear(clear), .start(start), .abort(abort),
    .busy(busy), .done(done),
    .madd_load(madd_load), .madd_run(madd_run), .madd_insn(madd_insn),
    .madd_index(madd_index), .madd_data(madd_data), .madd_result(madd_result),
    .res_valid(res_valid), .res_data(res_data)
  );

  // Datapath stand-in: the picked value appears exactly EXEC_LAT cycles after run, its inverse otherwise.
  logic        r1 = 1'b0, r2 = 1'b0;
  logic [11:0] v1 = '0, v2 = '0, dm_pick = '0;
  logic [11:0] sb[$];
  bit          fix_pick = 1'b0;
  always @(posedge clk) begin
    r1 <= madd_run;
    r2 <= r1;
    v2 <= v1;
    if (madd_run) begin
      v1 <= dm_pick;
      sb.push_back(dm_pick);
    end
  end
  assign madd_result = r2 ? v2 : ~v2;

  typedef struct packed {
    logic       rdy, busy, done, load, run, rv;
    logic [1:0] insn;
    logic [3:0] idx, dat;
  } obs_t;

  typedef struct {
    logic        v;
    logic [11:0] w;
    logic        clr, st;
    logic        e_rdy, e_busy, e_done;
  } vec_t;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [11:0] prog[$];
  obs_t        exp_tl[$];
  bit          pend_rv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] mk(input int k, input int n, input int x, input int d);
    return {2'(k), 2'(n), 4'(x), 4'(d)};
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.rdy = cmd_ready; o.busy = busy; o.done = done;
    o.load = madd_load; o.run = madd_run; o.rv = res_valid;
    o.insn = madd_insn; o.idx = madd_index; o.dat = madd_data;
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_tl(input obs_t e);
    obs_t t;
    t = e;
    if (pend_rv) begin
      t.rv = 1'b1;
      pend_rv = 1'b0;
    end
    exp_tl.push_back(t);
  endtask

  // Expected per-cycle outputs, cycle 0 being the one where start is driven.
  task automatic build_tl();
    obs_t        b, e;
    int          pc;
    bit          halted;
    logic [11:0] w;
    exp_tl.delete();
    pend_rv = 1'b0;
    b = '0;
    b.busy = 1'b1;
    exp_tl.push_back(obs_t'('0));
    pc = 0;
    halted = (prog.size() == 0);
    if (halted) begin
      e = b; e.done = 1'b1; push_tl(e);
    end
    while (!halted) begin
      push_tl(b);
      if (pc == prog.size()) begin
        e = b; e.done = 1'b1; push_tl(e);
        halted = 1'b1;
      end else begin
        w = prog[pc];
        pc++;
        e = b; e.insn = w[9:8]; e.idx = w[7:4]; e.dat = w[3:0];
        case (w[11:10])
          2'b00: begin
            e.load = 1'b1; push_tl(e);
          end
          2'b01: begin
            e.run = 1'b1; push_tl(e);
            e.run = 1'b0;
            for (int i = 1; i < EXEC_LAT; i++) push_tl(e);
            push_tl(b);
            pend_rv = 1'b1;
          end
          2'b10: begin
            push_tl(e);
            for (int i = 0; i <= int'(w[3:0]); i++) push_tl(b);
          end
          default: begin
            push_tl(e);
            e = b; e.done = 1'b1; push_tl(e);
            halted = 1'b1;
          end
        endcase
      end
    end
    e = '0;
    e.rdy = (prog.size() < DEPTH);
    push_tl(e);
  endtask

  task automatic run_prog(input string tag);
    obs_t o;
    build_tl();
    sb.delete();
    foreach (exp_tl[k]) begin
      start = (k == 0);
      if (!fix_pick) dm_pick = 12'($urandom);
      @(negedge clk);
      o = sample();
      chk($sformatf("%s cyc%0d", tag, k), 32'(o), 32'(exp_tl[k]));
      if (o.rv && exp_tl[k].rv) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL %s res_data cyc%0d: got %h with no result outstanding", tag, k, res_data);
        end else begin
          chk($sformatf("%s res_data cyc%0d", tag, k), 32'(res_data), 32'(sb.pop_front()));
        end
      end
      tick();
    end
    start = 1'b0;
  endtask

  task automatic load_prog();
    foreach (prog[i]) begin
      cmd_valid = 1'b0;
      repeat ($urandom_range(0, 1)) tick();
      cmd_valid = 1'b1;
      cmd_word  = prog[i];
      @(negedge clk);
      chk($sformatf("cmd_ready w%0d", i), 32'(cmd_ready), 32'd1);
      tick();
    end
    cmd_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    chk("cmd_ready during clear", 32'(cmd_ready), 32'd0);
    tick();
    clear = 1'b0;
    @(negedge clk);
    chk("cmd_ready after clear", 32'(cmd_ready), 32'd1);
    tick();
  endtask

  initial begin
    vec_t tbl[15];
    obs_t e;
    int   n, r, kd;

    tbl[0]  = '{1'b1, mk(0, 0, 3, 5), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, mk(0, 0, 1, 1), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 12'h000,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 12'h000,        1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[4]  = '{1'b0, 12'h000,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, mk(0, 0, 2, 2), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 12'h000,        1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, mk(3, 0, 0, 0), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 12'h000,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 12'h000,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b1, mk(0, 0, 4, 4), 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 12'h000,        1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 12'h000,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 12'h000,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 12'h000,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    // Reset state, while asserted and just after release.
    e = '0;
    e.rdy = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    chk("reset outputs", 32'(sample()), 32'(e));
    chk("reset res_data", 32'(res_data), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("idle outputs", 32'(sample()), 32'(e));
    tick();

    // IDLE handshake: clear, start priority, empty start, start while busy.
    for (int i = 0; i < 15; i++) begin
      cmd_valid = tbl[i].v;
      cmd_word  = tbl[i].w;
      clear     = tbl[i].clr;
      start     = tbl[i].st;
      @(negedge clk);
      chk($sformatf("tbl%0d rdy/busy/done", i), 32'({cmd_ready, busy, done}),
          32'({tbl[i].e_rdy, tbl[i].e_busy, tbl[i].e_done}));
      tick();
    end
    cmd_valid = 1'b0; clear = 1'b0; start = 1'b0;

    // Fill to DEPTH, refuse one more, then run the full buffer.
    prog.delete();
    for (int i = 0; i < DEPTH; i++) prog.push_back(mk(0, i % 4, i, 15 - i));
    load_prog();
    cmd_valid = 1'b1;
    cmd_word  = mk(3, 0, 0, 0);
    @(negedge clk);
    chk("cmd_ready when full", 32'(cmd_ready), 32'd0);
    tick();
    cmd_valid = 1'b0;
    run_prog("full");
    do_clear();

    prog = '{mk(0, 0, 3, 5), mk(3, 0, 0, 0)};
    load_prog();
    run_prog("load");
    do_clear();

    prog = '{mk(2, 0, 0, 3), mk(0, 0, 0, 1)};
    load_prog();
    run_prog("delay");
    do_clear();

    fix_pick = 1'b1;
    dm_pick  = 12'hA5C;
    prog = '{mk(1, 2, 1, 4), mk(3, 0, 0, 0)};
    load_prog();
    run_prog("exec");
    fix_pick = 1'b0;
    repeat (3) tick();
    chk("exec res_data held", 32'(res_data), 32'hA5C);
    do_clear();

    // Abort while the load strobe would be up.
    prog = '{mk(0, 0, 0, 1), mk(1, 1, 2, 3), mk(3, 0, 0, 0)};
    load_prog();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    abort = 1'b1;
    @(negedge clk);
    chk("abort issue load low", 32'({madd_load, madd_run}), 32'd0);
    tick();
    abort = 1'b0;
    @(negedge clk);
    chk("abort issue busy/done", 32'({busy, done}), 32'd0);
    tick();

    // Abort during EXWAIT, then replay from entry 0.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("abort run issued", 32'(madd_run), 32'd1);
    tick();
    abort = 1'b1;
    @(negedge clk);
    chk("abort exwait strobes", 32'({madd_load, madd_run, busy}), 32'b001);
    tick();
    abort = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("post-abort %0d busy/done/rv", i), 32'({busy, done, res_valid}), 32'd0);
      tick();
    end
    run_prog("replay");

    for (int p = 0; p < 25; p++) begin
      if (p == 0 || $urandom_range(0, 3) != 0) begin
        do_clear();
        prog.delete();
        n = $urandom_range(0, DEPTH);
        for (int i = 0; i < n; i++) begin
          r  = $urandom_range(0, 15);
          kd = (r < 5) ? 0 : (r < 10) ? 1 : (r < 14) ? 2 : 3;
          prog.push_back(mk(kd, $urandom_range(0, 3), $urandom_range(0, 15),
                            (kd == 2) ? $urandom_range(0, 5) : $urandom_range(0, 15)));
        end
        load_prog();
      end
      run_prog($sformatf("rnd%0d", p));
    end

    // Reset in the middle of a run drops the program and the last result.
    prog = '{mk(1, 1, 1, 1), mk(2, 0, 0, 9), mk(3, 0, 0, 0)};
    do_clear();
    load_prog();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mid-run reset res_data", 32'(res_data), 32'd0);
    tick();
    prog.delete();
    run_prog("after reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
